// File: rtl/mef_enchimento.sv
// Filling-station controller: moves a bottle under the nozzle, fills it, transfers it to
// the sealing stage and waits for the sealing stage to finish. Raises an alarm on timeouts.
module mef_enchimento #(
  parameter int MOVE_TIMEOUT = 30,
  parameter int FILL_TIMEOUT = 20,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sensor_gar,
  input  logic             sensor_nivel,
  input  logic             sensor_pos,
  input  logic             done_ved,
  input  logic             clr_alarme,
  output logic             motor,
  output logic             valvula,
  output logic             gar,
  output logic             pos,
  output logic             alarme_ench,
  output logic [CNT_W-1:0] cheias
);

  localparam int TMAX  = (MOVE_TIMEOUT > FILL_TIMEOUT) ? MOVE_TIMEOUT : FILL_TIMEOUT;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MOVE      = 3'd1;
  localparam logic [2:0] S_FILL      = 3'd2;
  localparam logic [2:0] S_TRANSFER  = 3'd3;
  localparam logic [2:0] S_WAIT_SEAL = 3'd4;
  localparam logic [2:0] S_ALARM     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cheias_q, cheias_d;

  // Sensors are tested before the timeout so a sensor on the last allowed cycle wins.
  always_comb begin
    state_d  = state_q;
    cheias_d = cheias_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (sensor_gar)               state_d = S_FILL;
        else if (timer_q == MOVE_LAST) state_d = S_ALARM;
      end
      S_FILL: begin
        if (sensor_nivel) begin
          state_d  = S_TRANSFER;
          cheias_d = cheias_q + CNT_W'(1);
        end else if (timer_q == FILL_LAST) begin
          state_d = S_ALARM;
        end
      end
      S_TRANSFER: begin
        if (sensor_pos)               state_d = S_WAIT_SEAL;
        else if (timer_q == MOVE_LAST) state_d = S_ALARM;
      end
      S_WAIT_SEAL: begin
        if (done_ved) state_d = start ? S_MOVE : S_IDLE;
      end
      S_ALARM: begin
        if (clr_alarme) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer restarts on every state entry and only runs in the timed states.
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) &&
        (state_q == S_MOVE || state_q == S_FILL || state_q == S_TRANSFER))
      timer_d = timer_q + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cheias_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cheias_q <= cheias_d;
    end
  end

  // Outputs decode the state register alone, so an async reset clears them at once.
  always_comb begin
    motor       = 1'b0;
    valvula     = 1'b0;
    gar         = 1'b0;
    pos         = 1'b0;
    alarme_ench = 1'b0;
    case (state_q)
      S_MOVE:      motor = 1'b1;
      S_FILL:      valvula = 1'b1;
      S_TRANSFER:  begin motor = 1'b1; gar = 1'b1; end
      S_WAIT_SEAL: begin gar = 1'b1; pos = 1'b1; end
      S_ALARM:     alarme_ench = 1'b1;
      default:     ;
    endcase
  end

  assign cheias = cheias_q;

endmodule

// File: tb/tb_mef_enchimento.sv
// Directed bench for mef_enchimento: full bottle sequence, timeouts, sensor priority,
// start drop, async reset and counter wrap.
module tb_mef_enchimento;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sensor_gar = 1'b0;
  logic       sensor_nivel = 1'b0;
  logic       sensor_pos = 1'b0;
  logic       done_ved = 1'b0;
  logic       clr_alarme = 1'b0;
  logic       motor, valvula, gar, pos, alarme_ench;
  logic [7:0] cheias;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_cnt = 8'd0;

  // {motor, valvula, gar, pos, alarme_ench} per state
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_MOVE = 5'b10000;
  localparam logic [4:0] O_FILL = 5'b01000;
  localparam logic [4:0] O_TRAN = 5'b10100;
  localparam logic [4:0] O_WAIT = 5'b00110;
  localparam logic [4:0] O_ALRM = 5'b00001;

  logic [4:0] obs;
  assign obs = {motor, valvula, gar, pos, alarme_ench};

  mef_enchimento #(.MOVE_TIMEOUT(30), .FILL_TIMEOUT(20), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sensor_gar(sensor_gar),
    .sensor_nivel(sensor_nivel), .sensor_pos(sensor_pos), .done_ved(done_ved),
    .clr_alarme(clr_alarme), .motor(motor), .valvula(valvula), .gar(gar), .pos(pos),
    .alarme_ench(alarme_ench), .cheias(cheias)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (motor && valvula) begin
        n_fail++;
        $display("FAIL motor_valvula_exclusive: motor=%b valvula=%b required not both 1", motor, valvula);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_bottle();
    repeat (4) tick();
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    repeat (2) tick();
    sensor_nivel = 1'b1; tick(); sensor_nivel = 1'b0;
    repeat (3) tick();
    sensor_pos = 1'b1; tick(); sensor_pos = 1'b0;
    tick();
    done_ved = 1'b1; tick(); done_ved = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if (obs !== O_IDLE || cheias !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: outs=%b cheias=%0d required outs=%b cheias=0", obs, cheias, O_IDLE);
    end
    repeat (2) tick();
    reset = 1'b0;
    exp_cnt = 8'd0;
    tick();
    n_checks++;
    if (obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL idle_after_reset: outs=%b required %b", obs, O_IDLE);
    end
  endtask

  task automatic test_full_sequence();
    start = 1'b1;
    tick();
    n_checks++;
    if (obs !== O_MOVE) begin n_fail++; $display("FAIL seq_move_entry: outs=%b required %b", obs, O_MOVE); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== O_MOVE) begin n_fail++; $display("FAIL seq_move_hold%0d: outs=%b required %b", i, obs, O_MOVE); end
    end
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    n_checks++;
    if (obs !== O_FILL) begin n_fail++; $display("FAIL seq_fill: outs=%b required %b", obs, O_FILL); end
    repeat (2) tick();
    n_checks++;
    if (obs !== O_FILL || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL seq_fill_hold: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_FILL, exp_cnt);
    end
    sensor_nivel = 1'b1; tick(); sensor_nivel = 1'b0;
    exp_cnt++;
    n_checks++;
    if (obs !== O_TRAN || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL seq_transfer: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_TRAN, exp_cnt);
    end
    repeat (3) tick();
    sensor_pos = 1'b1; tick(); sensor_pos = 1'b0;
    n_checks++;
    if (obs !== O_WAIT) begin n_fail++; $display("FAIL seq_wait_seal: outs=%b required %b", obs, O_WAIT); end
    tick();
    n_checks++;
    if (obs !== O_WAIT) begin n_fail++; $display("FAIL seq_wait_hold: outs=%b required %b", obs, O_WAIT); end
    done_ved = 1'b1; tick(); done_ved = 1'b0;
    n_checks++;
    if (obs !== O_MOVE || cheias !== 8'd1) begin
      n_fail++; $display("FAIL seq_back_to_move: outs=%b cheias=%0d required %b/1", obs, cheias, O_MOVE);
    end
  endtask

  task automatic test_fill_timeout();
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    for (int i = 1; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== O_FILL) begin n_fail++; $display("FAIL fill_to_hold%0d: outs=%b required %b", i, obs, O_FILL); end
    end
    tick();
    n_checks++;
    if (obs !== O_ALRM || valvula !== 1'b0) begin
      n_fail++; $display("FAIL fill_to_alarm: outs=%b required %b", obs, O_ALRM);
    end
    repeat (3) tick();
    n_checks++;
    if (obs !== O_ALRM || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL alarm_sticky: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_ALRM, exp_cnt);
    end
    start = 1'b0; clr_alarme = 1'b1; tick(); clr_alarme = 1'b0;
    n_checks++;
    if (obs !== O_IDLE || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL alarm_clear: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_IDLE, exp_cnt);
    end
  endtask

  task automatic test_timeouts();
    // sensor_gar arrives on the cycle where timer==29
    start = 1'b1; tick();
    repeat (29) tick();
    n_checks++;
    if (obs !== O_MOVE) begin n_fail++; $display("FAIL move_before_limit: outs=%b required %b", obs, O_MOVE); end
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    n_checks++;
    if (obs !== O_FILL || alarme_ench !== 1'b0) begin
      n_fail++; $display("FAIL sensor_wins_move: outs=%b required %b", obs, O_FILL);
    end
    sensor_nivel = 1'b1; tick(); sensor_nivel = 1'b0; exp_cnt++;
    sensor_pos = 1'b1; tick(); sensor_pos = 1'b0;
    start = 1'b0; done_ved = 1'b1; tick(); done_ved = 1'b0;
    n_checks++;
    if (obs !== O_IDLE || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL quick_bottle_idle: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_IDLE, exp_cnt);
    end
    // plain move timeout
    start = 1'b1; tick();
    repeat (29) tick();
    tick();
    n_checks++;
    if (obs !== O_ALRM) begin n_fail++; $display("FAIL move_timeout: outs=%b required %b", obs, O_ALRM); end
    start = 1'b0; clr_alarme = 1'b1; tick(); clr_alarme = 1'b0;
    // transfer timeout
    start = 1'b1; tick();
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    sensor_nivel = 1'b1; tick(); sensor_nivel = 1'b0; exp_cnt++;
    repeat (29) tick();
    n_checks++;
    if (obs !== O_TRAN) begin n_fail++; $display("FAIL transfer_before_limit: outs=%b required %b", obs, O_TRAN); end
    tick();
    n_checks++;
    if (obs !== O_ALRM || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL transfer_timeout: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_ALRM, exp_cnt);
    end
    start = 1'b0; clr_alarme = 1'b1; tick(); clr_alarme = 1'b0;
    n_checks++;
    if (obs !== O_IDLE) begin n_fail++; $display("FAIL transfer_alarm_clear: outs=%b required %b", obs, O_IDLE); end
  endtask

  task automatic test_start_drop();
    start = 1'b1; tick();
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    start = 1'b0; tick();
    n_checks++;
    if (obs !== O_FILL) begin n_fail++; $display("FAIL drop_fill_continues: outs=%b required %b", obs, O_FILL); end
    sensor_nivel = 1'b1; tick(); sensor_nivel = 1'b0; exp_cnt++;
    n_checks++;
    if (obs !== O_TRAN || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL drop_transfer: outs=%b cheias=%0d required %b/%0d", obs, cheias, O_TRAN, exp_cnt);
    end
    sensor_pos = 1'b1; tick(); sensor_pos = 1'b0;
    tick();
    n_checks++;
    if (obs !== O_WAIT) begin n_fail++; $display("FAIL drop_wait: outs=%b required %b", obs, O_WAIT); end
    done_ved = 1'b1; tick(); done_ved = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== O_IDLE || motor !== 1'b0) begin
        n_fail++; $display("FAIL drop_idle%0d: outs=%b required %b", i, obs, O_IDLE);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick();
    sensor_gar = 1'b1; tick(); sensor_gar = 1'b0;
    tick();
    n_checks++;
    if (valvula !== 1'b1 || cheias !== exp_cnt) begin
      n_fail++; $display("FAIL pre_reset_fill: valvula=%b cheias=%0d required 1/%0d", valvula, cheias, exp_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (valvula !== 1'b0 || cheias !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: valvula=%b cheias=%0d required 0/0", valvula, cheias);
    end
    start = 1'b0;
    #1 reset = 1'b0;
    exp_cnt = 8'd0;
    tick();
    n_checks++;
    if (obs !== O_IDLE || cheias !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_idle: outs=%b cheias=%0d required %b/0", obs, cheias, O_IDLE);
    end
  endtask

  task automatic test_wrap();
    start = 1'b1; tick();
    for (int b = 0; b < 256; b++) begin
      run_bottle();
      if (b == 254) begin
        n_checks++;
        if (cheias !== 8'd255) begin n_fail++; $display("FAIL wrap_255: cheias=%0d required 255", cheias); end
      end
    end
    n_checks++;
    if (cheias !== 8'd0 || obs !== O_MOVE) begin
      n_fail++; $display("FAIL wrap_zero: cheias=%0d outs=%b required 0/%b", cheias, obs, O_MOVE);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_fill_timeout();
    test_timeouts();
    test_start_drop();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
